// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU/mux select codes and the packed control word.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_MEM    = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       instr_retired;
`ifdef ILLEGAL_TRAP_EN
        logic       illegal_instr;
`endif
    } ctrl_t;

    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decode for the multicycle controller.
// Build option ILLEGAL_TRAP_EN: adds the TRAP illegal_instr flag.
module mc_ctrl_outdec
    import rv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       zero,
    input  logic       mem_ready,
`ifndef ILLEGAL_TRAP_EN
    input  logic       illegal_op,
`endif
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRC_A_PC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.result_src = RESULT_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
`ifndef ILLEGAL_TRAP_EN
                ctrl.instr_retired = illegal_op;
`endif
            end
            MEMADR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            MEMREAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RESULT_ALUOUT;
            end
            MEMWB: begin
                ctrl.result_src    = RESULT_MEM;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            MEMWRITE: begin
                ctrl.mem_req       = 1'b1;
                ctrl.mem_write     = 1'b1;
                ctrl.adr_src       = 1'b1;
                ctrl.result_src    = RESULT_ALUOUT;
                ctrl.instr_retired = mem_ready;
            end
            EXECR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            EXECI: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ALUWB: begin
                ctrl.result_src    = RESULT_ALUOUT;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            BEQ: begin
                ctrl.alu_src_a     = SRC_A_RS1;
                ctrl.alu_src_b     = SRC_B_RS2;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.result_src    = RESULT_ALUOUT;
                ctrl.pc_write      = zero;
                ctrl.instr_retired = 1'b1;
            end
            JAL: begin
                ctrl.alu_src_a  = SRC_A_OLDPC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.result_src = RESULT_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: ctrl.illegal_instr = 1'b1;
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core with memory wait watchdog.
// Build option ILLEGAL_TRAP_EN: unknown opcodes park in TRAP and raise illegal_instr.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_retired,
    output logic       mem_timeout,
`ifdef ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic [3:0] state_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    state_t           state_q, state_d;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;
    logic             mem_entry;
    ctrl_t            ctrl_raw, ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run_q) begin
            case (state_q)
                FETCH:    if (mem_ready) state_d = DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = MEMADR;
                        OP_RTYPE:          state_d = EXECR;
                        OP_ITYPE:          state_d = EXECI;
                        OP_BRANCH:         state_d = BEQ;
                        OP_JAL:            state_d = JAL;
`ifdef ILLEGAL_TRAP_EN
                        default:           state_d = TRAP;
`else
                        default:           state_d = FETCH;
`endif
                    endcase
                end
                MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state_d = MEMWB;
                MEMWB:    state_d = FETCH;
                MEMWRITE: if (mem_ready) state_d = FETCH;
                EXECR:    state_d = ALUWB;
                EXECI:    state_d = ALUWB;
                ALUWB:    state_d = FETCH;
                BEQ:      state_d = FETCH;
                JAL:      state_d = ALUWB;
                TRAP:     state_d = TRAP;
                default:  state_d = FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .state      (state_q),
        .zero       (zero),
        .mem_ready  (mem_ready),
`ifndef ILLEGAL_TRAP_EN
        .illegal_op (!is_known_op(opcode)),
`endif
        .ctrl       (ctrl_raw)
    );

    // Nothing but the debug state leaves the block until the first post-reset edge
    always_comb begin
        ctrl = '0;
        if (run_q) ctrl = ctrl_raw;
    end

    assign mem_req       = ctrl.mem_req;
    assign mem_write     = ctrl.mem_write;
    assign adr_src       = ctrl.adr_src;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign result_src    = ctrl.result_src;
    assign instr_retired = ctrl.instr_retired;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = ctrl.illegal_instr;
`endif
    assign mem_timeout   = run_q & timeout_q;
    assign state_dbg     = state_q;

    assign mem_entry = run_q && (state_d != state_q) && is_mem_state(state_d);

    always_comb begin
        cnt_d = cnt_q;
        if (mem_entry || mem_ready)
            cnt_d = '0;
        else if (ctrl.mem_req && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    // Watchdog only flags; the FSM keeps waiting on the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if ((WAIT_MAX != 0) && (cnt_d == CNT_MAX))
                timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl: per-cycle table plus trap and timeout/reset sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_retired, mem_timeout;
    logic [3:0] state_dbg;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .instr_retired(instr_retired), .mem_timeout(mem_timeout),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr(illegal_instr),
`endif
        .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwr, adr, irw, pcw, rw;
        logic [1:0] sa, sb, aop, rs;
        logic       ret, to;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        logic       z;
        logic       rdy;
        obs_t       exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic obs_t o(input logic [3:0] st, input logic mreq, mwr, adr, irw, pcw, rw,
                               input logic [1:0] sa, sb, aop, rs, input logic ret, to);
        return {st, mreq, mwr, adr, irw, pcw, rw, sa, sb, aop, rs, ret, to};
    endfunction

    function automatic void add(input logic [6:0] op, input logic z, input logic rdy, input obs_t e);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input obs_t e);
        obs_t act;
        act = {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, instr_retired, mem_timeout};
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got st=%0d ctl=%b exp st=%0d ctl=%b", nm,
                     act.st, act[15:0], e.st, e[15:0]);
        end
    endtask

    // Drive at the falling edge, sample 1ns later, then advance one clock
    task automatic step(input string nm, input logic [6:0] op, input logic z, input logic rdy,
                        input obs_t e);
        opcode = op; zero = z; mem_ready = rdy;
        #1 check(nm, e);
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

    obs_t ZERO, F_HIT, F_WAIT, DEC, MADR, MRD, MWB, MWR, MWR_DONE, EXR, EXI, AWB, JALS;

    initial begin
        ZERO     = o(0, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
        F_HIT    = o(0, 1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
        F_WAIT   = o(0, 1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
        DEC      = o(1, 0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
        MADR     = o(2, 0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
        MRD      = o(3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
        MWB      = o(4, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 1,0);
        MWR      = o(5, 1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
        MWR_DONE = o(5, 1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0);
        EXR      = o(6, 0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0);
        EXI      = o(7, 0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0,0);
        AWB      = o(8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
        JALS     = o(10,0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0,0);

        // First row: run_q still 0, mem_ready must not start a fetch
        add(LW, 0, 1, ZERO);
        add(LW, 0, 0, F_WAIT);
        add(LW, 0, 1, F_HIT);  add(LW, 0, 1, DEC);  add(LW, 0, 1, MADR);
        add(LW, 0, 1, MRD);    add(LW, 0, 1, MWB);
        add(SW, 0, 1, F_HIT);  add(SW, 0, 1, DEC);  add(SW, 0, 1, MADR);
        add(SW, 0, 0, MWR);    add(SW, 0, 0, MWR);  add(SW, 0, 0, MWR);
        add(SW, 0, 1, MWR_DONE);
        add(BR, 0, 1, F_HIT);  add(BR, 0, 1, DEC);
        add(BR, 1, 1, o(9, 0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 1,0));
        add(BR, 0, 1, F_HIT);  add(BR, 0, 1, DEC);
        add(BR, 0, 1, o(9, 0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0));
        add(RT, 1, 1, F_HIT);  add(RT, 1, 1, DEC);  add(RT, 1, 1, EXR);  add(RT, 1, 1, AWB);
        add(IT, 0, 1, F_HIT);  add(IT, 0, 1, DEC);  add(IT, 0, 1, EXI);  add(IT, 0, 1, AWB);
        add(JL, 0, 1, F_HIT);  add(JL, 0, 1, DEC);  add(JL, 0, 1, JALS); add(JL, 0, 1, AWB);

        rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset", ZERO);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].exp);

        // Unknown opcode
        step("bad_fetch", BAD, 0, 1, F_HIT);
`ifdef ILLEGAL_TRAP_EN
        step("bad_decode", BAD, 0, 1, DEC);
        for (int k = 0; k < 3; k++) begin
            opcode = BAD; mem_ready = 1'b1;
            #1 check($sformatf("trap%0d", k), o(11, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
            n_vec++;
            if (illegal_instr !== 1'b1) begin
                n_err++;
                $display("FAIL illegal_instr%0d: got %b exp 1", k, illegal_instr);
            end
            @(posedge clk);
            @(negedge clk);
        end
`else
        step("bad_decode", BAD, 0, 1, o(1, 0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 1,0));
        step("bad_next", BAD, 0, 0, F_WAIT);
`endif

        // Reset, then a load stalled long enough to trip the watchdog
        rst_n = 1'b0;
        #1 check("rst_async", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        step("rel_idle", LW, 0, 1, ZERO);
        step("to_fetch", LW, 0, 1, F_HIT);
        step("to_decode", LW, 0, 1, DEC);
        step("to_madr", LW, 0, 1, MADR);
        for (int k = 0; k < 20; k++)
            step($sformatf("wait%0d", k), LW, 0, 0,
                 o(3, 1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0, (k >= 15)));
        rst_n = 1'b0;
        #1 check("rst_mid_memread", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_idle", ZERO);
        @(posedge clk);
        @(negedge clk);
        #1 check("post_rst_fetch", F_WAIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
